// File: rtl/attack_pkg.sv
// rtl/attack_pkg.sv - shared encodings, widths and default timing for attack_fsm
package attack_pkg;

  // Damage width matches the health-management datapath.
  localparam int DMG_W  = 9;
  localparam int CNT_W  = 8;
  localparam int ANIM_W = 3;

  // anim_state layout: {is_heavy, phase[1:0]}
  localparam int ANIM_HEAVY_BIT = 2;

  localparam logic [1:0] PH_IDLE     = 2'b00;
  localparam logic [1:0] PH_STARTUP  = 2'b01;
  localparam logic [1:0] PH_ACTIVE   = 2'b10;
  localparam logic [1:0] PH_RECOVERY = 2'b11;

  // State values equal the phase code so the sprite phase is the state itself.
  typedef enum logic [1:0] {
    ST_IDLE     = PH_IDLE,
    ST_STARTUP  = PH_STARTUP,
    ST_ACTIVE   = PH_ACTIVE,
    ST_RECOVERY = PH_RECOVERY
  } state_e;

  localparam int DEF_LIGHT_STARTUP  = 2;
  localparam int DEF_LIGHT_ACTIVE   = 2;
  localparam int DEF_LIGHT_RECOVERY = 3;
  localparam int DEF_LIGHT_DAMAGE   = 10;
  localparam int DEF_HEAVY_STARTUP  = 4;
  localparam int DEF_HEAVY_ACTIVE   = 3;
  localparam int DEF_HEAVY_RECOVERY = 6;
  localparam int DEF_HEAVY_DAMAGE   = 25;
  localparam int DEF_COMBO_BONUS    = 5;

  // A phase of N frames counts N-1 down to 0.
  function automatic logic [CNT_W-1:0] frame_load(input int frames);
    return CNT_W'(frames - 1);
  endfunction

  function automatic logic [ANIM_W-1:0] pack_anim(input logic is_heavy, input logic [1:0] phase);
    return {is_heavy, phase};
  endfunction

endpackage

// File: rtl/attack_fsm_rise_detect.sv
// rtl/attack_fsm_rise_detect.sv - 1-bit rising-edge detector, prev presets to 1 in reset
module rise_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  // Next previous-value is simply the current input.
  always_comb begin
    prev_d = din;
  end

  // Preset to 1 so a level held through reset is not seen as a new press.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = din & ~prev_q;

endmodule

// File: rtl/attack_fsm.sv
// rtl/attack_fsm.sv - per-player attack sequencer (optional chaining: ATTACK_FSM_COMBO_EN)
module attack_fsm
  import attack_pkg::*;
#(
  parameter int LIGHT_STARTUP  = DEF_LIGHT_STARTUP,
  parameter int LIGHT_ACTIVE   = DEF_LIGHT_ACTIVE,
  parameter int LIGHT_RECOVERY = DEF_LIGHT_RECOVERY,
  parameter int LIGHT_DAMAGE   = DEF_LIGHT_DAMAGE,
  parameter int HEAVY_STARTUP  = DEF_HEAVY_STARTUP,
  parameter int HEAVY_ACTIVE   = DEF_HEAVY_ACTIVE,
  parameter int HEAVY_RECOVERY = DEF_HEAVY_RECOVERY,
  parameter int HEAVY_DAMAGE   = DEF_HEAVY_DAMAGE,
  parameter int COMBO_BONUS    = DEF_COMBO_BONUS
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             btn_light,
  input  logic             btn_heavy,
  input  logic             in_range,
  input  logic             stunned,
  output logic             hit_valid,
  output logic [DMG_W-1:0] hit_damage,
  output logic [2:0]       anim_state,
  output logic             busy,
  output logic [1:0]       combo_level
);

  logic rise_light;
  logic rise_heavy;

  rise_detect u_rise_light (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (btn_light),
    .rise    (rise_light)
  );

  rise_detect u_rise_heavy (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (btn_heavy),
    .rise    (rise_heavy)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_heavy_q, is_heavy_d;
  logic               hit_done_q, hit_done_d;
  logic               hit_valid_q, hit_valid_d;
  logic [DMG_W-1:0]   hit_damage_q, hit_damage_d;
  logic [ANIM_W-1:0]  anim_q, anim_d;
  logic               busy_q, busy_d;
  logic [1:0]         combo_lvl;
  logic [DMG_W-1:0]   light_dmg;

`ifdef ATTACK_FSM_COMBO_EN
  logic [1:0] combo_q, combo_d;
  assign combo_lvl = combo_q;
`else
  assign combo_lvl = 2'b00;
`endif

  // Light damage grows with the chain step; with chaining off the step is always 0.
  assign light_dmg = DMG_W'(LIGHT_DAMAGE) + DMG_W'(combo_lvl) * DMG_W'(COMBO_BONUS);

  // Next state, frame counter, hit pulse and registered sprite/busy outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    is_heavy_d   = is_heavy_q;
    hit_done_d   = hit_done_q;
    hit_valid_d  = 1'b0;
    hit_damage_d = '0;
`ifdef ATTACK_FSM_COMBO_EN
    combo_d      = combo_q;
`endif

    // One hit per attack, only while the hitbox is live.
    if (state_q == ST_ACTIVE && in_range && !hit_done_q) begin
      hit_valid_d  = 1'b1;
      hit_damage_d = is_heavy_q ? DMG_W'(HEAVY_DAMAGE) : light_dmg;
      hit_done_d   = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (rise_heavy) begin
          state_d    = ST_STARTUP;
          is_heavy_d = 1'b1;
          cnt_d      = frame_load(HEAVY_STARTUP);
          hit_done_d = 1'b0;
        end else if (rise_light) begin
          state_d    = ST_STARTUP;
          is_heavy_d = 1'b0;
          cnt_d      = frame_load(LIGHT_STARTUP);
          hit_done_d = 1'b0;
        end
      end

      ST_STARTUP: begin
        if (cnt_q == '0) begin
          state_d = ST_ACTIVE;
          cnt_d   = is_heavy_q ? frame_load(HEAVY_ACTIVE) : frame_load(LIGHT_ACTIVE);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_ACTIVE: begin
        if (cnt_q == '0) begin
          state_d = ST_RECOVERY;
          cnt_d   = is_heavy_q ? frame_load(HEAVY_RECOVERY) : frame_load(LIGHT_RECOVERY);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_RECOVERY: begin
`ifdef ATTACK_FSM_COMBO_EN
        if (rise_light && !is_heavy_q && combo_q < 2'd2) begin
          state_d    = ST_STARTUP;
          cnt_d      = frame_load(LIGHT_STARTUP);
          hit_done_d = 1'b0;
          combo_d    = combo_q + 2'd1;
        end else
`endif
        if (cnt_q == '0) begin
          state_d    = ST_IDLE;
          cnt_d      = '0;
          is_heavy_d = 1'b0;
`ifdef ATTACK_FSM_COMBO_EN
          combo_d    = 2'd0;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Being hit cancels everything, including a hit landing this same frame.
    if (stunned) begin
      state_d      = ST_IDLE;
      cnt_d        = '0;
      is_heavy_d   = 1'b0;
      hit_valid_d  = 1'b0;
      hit_damage_d = '0;
`ifdef ATTACK_FSM_COMBO_EN
      combo_d      = 2'd0;
`endif
    end

    anim_d = (state_d == ST_IDLE) ? pack_anim(1'b0, PH_IDLE) : pack_anim(is_heavy_d, state_d);
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      is_heavy_q   <= 1'b0;
      hit_done_q   <= 1'b0;
      hit_valid_q  <= 1'b0;
      hit_damage_q <= '0;
      anim_q       <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_heavy_q   <= is_heavy_d;
      hit_done_q   <= hit_done_d;
      hit_valid_q  <= hit_valid_d;
      hit_damage_q <= hit_damage_d;
      anim_q       <= anim_d;
      busy_q       <= busy_d;
    end
  end

`ifdef ATTACK_FSM_COMBO_EN
  // Chain step register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      combo_q <= 2'd0;
    end else begin
      combo_q <= combo_d;
    end
  end
`endif

  assign hit_valid   = hit_valid_q;
  assign hit_damage  = hit_damage_q;
  assign anim_state  = anim_q;
  assign busy        = busy_q;
  assign combo_level = combo_lvl;

endmodule

// File: tb/tb_attack_fsm.sv
// tb/tb_attack_fsm.sv - self-checking bench for attack_fsm with a hit-damage scoreboard
module tb_attack_fsm;

  localparam int B_LS = 2, B_LA = 2, B_LR = 3, B_LD = 10;
  localparam int B_HS = 4, B_HA = 3, B_HR = 6, B_HD = 25;
  localparam int B_CB = 5;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn_light, btn_heavy, in_range, stunned;
  logic       hit_valid;
  logic [8:0] hit_damage;
  logic [2:0] anim_state;
  logic       busy;
  logic [1:0] combo_level;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;
  int exp_q[$];

  attack_fsm dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_light   (btn_light),
    .btn_heavy   (btn_heavy),
    .in_range    (in_range),
    .stunned     (stunned),
    .hit_valid   (hit_valid),
    .hit_damage  (hit_damage),
    .anim_state  (anim_state),
    .busy        (busy),
    .combo_level (combo_level)
  );

  always #5 clk = ~clk;

  // Scoreboard: every hit pulse must match the oldest expected damage.
  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      if (hit_valid) begin
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_hit: got damage %0d, required no hit", hit_damage);
        end else begin
          int e;
          e = exp_q.pop_front();
          if (hit_damage !== 9'(e)) begin
            n_fail++;
            $display("FAIL hit_damage: got %0d, required %0d", hit_damage, e);
          end
        end
      end else if (hit_damage !== 9'd0) begin
        n_fail++;
        $display("FAIL idle_damage: got %0d, required 0", hit_damage);
      end
    end
  end

  function automatic logic [2:0] exp_anim(input bit heavy, input int i);
    int s, a, r;
    s = heavy ? B_HS : B_LS;
    a = heavy ? B_HA : B_LA;
    r = heavy ? B_HR : B_LR;
    if (i < s)         return {heavy, 2'b01};
    if (i < s + a)     return {heavy, 2'b10};
    if (i < s + a + r) return {heavy, 2'b11};
    return 3'b000;
  endfunction

  // Caller is positioned at a negedge. mode 0: in range always, 1: only startup/recovery,
  // 2: only on last active frame. exp_hit is the sample index of the pulse (-1 none).
  task automatic run_attack(input string name, input bit heavy, input bit both,
                            input int mode, input int exp_hit);
    int s, a, r, tot, hit_at;
    logic [2:0] ea;
    s = heavy ? B_HS : B_LS;
    a = heavy ? B_HA : B_LA;
    r = heavy ? B_HR : B_LR;
    tot = s + a + r;
    hit_at = -1;
    if (exp_hit >= 0) exp_q.push_back(heavy ? B_HD : B_LD);
    btn_light = both | ~heavy;
    btn_heavy = heavy;
    in_range  = (mode == 0);
    for (int i = 0; i <= tot; i++) begin
      @(negedge clk);
      if (i == 0) begin
        btn_light = 1'b0;
        btn_heavy = 1'b0;
      end
      ea = exp_anim(heavy, i);
      n_checks++;
      if (anim_state !== ea) begin
        n_fail++;
        $display("FAIL %s anim[%0d]: got %b, required %b", name, i, anim_state, ea);
      end
      n_checks++;
      if (busy !== (i < tot)) begin
        n_fail++;
        $display("FAIL %s busy[%0d]: got %b, required %b", name, i, busy, (i < tot));
      end
      if (hit_valid && hit_at < 0) hit_at = i;
      case (mode)
        0:       in_range = 1'b1;
        1:       in_range = (i < s) || (i >= s + a);
        default: in_range = (i == s + a - 1);
      endcase
    end
    in_range = 1'b0;
    n_checks++;
    if (hit_at != exp_hit) begin
      n_fail++;
      $display("FAIL %s hit_index: got %0d, required %0d", name, hit_at, exp_hit);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; btn_light = 1'b1; btn_heavy = 1'b0; in_range = 1'b0; stunned = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({hit_valid, hit_damage, anim_state, busy, combo_level} !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0",
               {hit_valid, hit_damage, anim_state, busy, combo_level});
    end
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || anim_state !== 3'b000) begin
        n_fail++;
        $display("FAIL held_through_reset[%0d]: got busy=%b anim=%b, required 0/000", i, busy, anim_state);
      end
    end
    btn_light = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    run_attack("post_reset", 1'b0, 1'b0, 0, B_LS + 1);
  endtask

  task automatic test_light;
    run_attack("light", 1'b0, 1'b0, 0, B_LS + 1);
  endtask

  task automatic test_heavy_priority;
    run_attack("heavy_pri", 1'b1, 1'b1, 0, B_HS + 1);
  endtask

  task automatic test_range_edges;
    run_attack("range_off", 1'b0, 1'b0, 1, -1);
    run_attack("range_last", 1'b0, 1'b0, 2, B_LS + B_LA);
    run_attack("heavy_last", 1'b1, 1'b0, 2, B_HS + B_HA);
  endtask

  task automatic test_stun;
    btn_light = 1'b1;
    in_range  = 1'b1;
    for (int i = 0; i <= B_LS; i++) begin
      @(negedge clk);
      if (i == 0) btn_light = 1'b0;
    end
    stunned = 1'b1;
    @(negedge clk);
    stunned = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || anim_state !== 3'b000 || hit_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stun_cancel: got busy=%b anim=%b hit=%b, required 0/000/0", busy, anim_state, hit_valid);
    end
    run_attack("after_stun", 1'b0, 1'b0, 0, B_LS + 1);
  endtask

`ifdef ATTACK_FSM_COMBO_EN
  task automatic test_combo;
    int tot;
    logic [2:0] ea;
    tot = B_LS + B_LA + B_LR;
    for (int k = 0; k < 3; k++) exp_q.push_back(B_LD + k * B_CB);
    btn_light = 1'b1;
    in_range  = 1'b1;
    for (int step = 0; step < 3; step++) begin
      for (int i = 0; i <= B_LS + B_LA; i++) begin
        @(negedge clk);
        if (i == 0) btn_light = 1'b0;
        ea = exp_anim(1'b0, i);
        n_checks++;
        if (anim_state !== ea || combo_level !== 2'(step)) begin
          n_fail++;
          $display("FAIL combo step%0d[%0d]: got anim=%b lvl=%0d, required %b/%0d",
                   step, i, anim_state, combo_level, ea, step);
        end
      end
      btn_light = 1'b1;
    end
    for (int i = B_LS + B_LA + 1; i <= tot; i++) begin
      @(negedge clk);
      btn_light = 1'b0;
      ea = exp_anim(1'b0, i);
      n_checks++;
      if (anim_state !== ea || combo_level !== ((i == tot) ? 2'd0 : 2'd2)) begin
        n_fail++;
        $display("FAIL combo_tail[%0d]: got anim=%b lvl=%0d, required %b/%0d",
                 i, anim_state, combo_level, ea, (i == tot) ? 0 : 2);
      end
    end
    in_range = 1'b0;
  endtask
`else
  task automatic test_no_chain;
    int tot;
    logic [2:0] ea;
    tot = B_LS + B_LA + B_LR;
    exp_q.push_back(B_LD);
    btn_light = 1'b1;
    in_range  = 1'b1;
    for (int i = 0; i <= tot; i++) begin
      @(negedge clk);
      btn_light = (i == B_LS + B_LA);
      ea = exp_anim(1'b0, i);
      n_checks++;
      if (anim_state !== ea || combo_level !== 2'd0) begin
        n_fail++;
        $display("FAIL no_chain[%0d]: got anim=%b lvl=%0d, required %b/0", i, anim_state, combo_level, ea);
      end
    end
    btn_light = 1'b0;
    in_range  = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_light();
    test_heavy_priority();
    test_range_edges();
    test_stun();
`ifdef ATTACK_FSM_COMBO_EN
    test_combo();
`else
    test_no_chain();
`endif
    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending hits, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/attack_fsm.md
Name: attack_fsm

Overview:
Per-player attack sequencer clocked on the 20 Hz game tick. It sits directly upstream of the health-management stage and the sprite controller.
- Inputs: raw attack buttons plus the hit-range flag from collision detection.
- Outputs: a one-cycle hit event carrying a damage value, which health management consumes; and an animation code, which the sprite controller consumes.
- It replaces the direct button-to-health wiring with startup, active and recovery frame timing.

Parameters:
LIGHT_STARTUP, 2, frames before light hitbox is live (min 1)
LIGHT_ACTIVE, 2, frames light hitbox is live (min 1)
LIGHT_RECOVERY, 3, frames after light hitbox (min 1)
LIGHT_DAMAGE, 10, damage per light hit
HEAVY_STARTUP, 4, heavy startup frames (min 1)
HEAVY_ACTIVE, 3, heavy active frames (min 1)
HEAVY_RECOVERY, 6, heavy recovery frames (min 1)
HEAVY_DAMAGE, 25, damage per heavy hit
COMBO_BONUS, 5, extra damage per combo step (used only with COMBO_EN)

Ports:
clk  in  1  game clock (20 Hz tick domain)
reset_n  in  1  synchronous, active-low reset
btn_light  in  1  light attack button, level
btn_heavy  in  1  heavy attack button, level
in_range  in  1  opponent inside hit range
stunned  in  1  player was hit this frame; cancels the attack
hit_valid  out  1  one-cycle hit pulse to health management
hit_damage  out  9  damage value; 0 when hit_valid=0
anim_state  out  3  {is_heavy, phase[1:0]} to the sprite controller
busy  out  1  high in any non-IDLE state
combo_level  out  2  current combo step (0..2)

Behaviour:
- Reset (reset_n=0 at an edge):
  - state=IDLE; all outputs 0; frame counter 0; hit_done=0; combo_level=0.
  - Both button-previous registers load 1, so a button held through reset does not fire an attack on release of reset.
- Edge detect: rise = btn & ~btn_prev. btn_prev is registered every cycle.
- States: IDLE, STARTUP, ACTIVE, RECOVERY. phase encoding: 00 idle, 01 startup, 10 active, 11 recovery.
- IDLE:
  - On rise of heavy, go to STARTUP with is_heavy=1.
  - Else on rise of light, go to STARTUP with is_heavy=0.
  - Simultaneous rises: heavy wins.
  - Counter loads (STARTUP-1) of the selected attack type.
- Frame counting:
  - Each phase lasts exactly its parameter count in cycles. The counter decrements every cycle; at 0 the FSM advances to the next phase and loads (param-1).
  - RECOVERY at 0 returns to IDLE.
  - Total busy time is S+A+R cycles.
  - is_heavy is latched at entry and held until IDLE.
- Button rises while busy are ignored (see COMBO_EN for the exception).
- Hit generation:
  - Condition at an edge: state=ACTIVE, in_range=1, hit_done=0.
  - Effect: hit_valid<=1, hit_damage<=damage of the latched type, hit_done<=1.
  - At every other edge: hit_valid<=0 and hit_damage<=0.
  - At most one hit per attack. hit_done clears on entry to STARTUP.
  - Latency: the pulse is visible in the cycle after in_range is sampled.
  - If in_range rises during the last ACTIVE cycle, the hit still fires (one cycle later, while in RECOVERY). in_range during STARTUP or RECOVERY never hits.
- stunned=1 at any edge: state<=IDLE, hit_valid<=0, combo_level<=0. It takes priority over hit generation and button rises in the same cycle.
- anim_state and busy are registered and change on the same edge as state.

Optional Feature:
Macro: ATTACK_FSM_COMBO_EN
- Defined:
  - A light rise during RECOVERY of a light attack with combo_level<2 re-enters STARTUP (light): combo_level++, hit_done cleared.
  - Damage becomes LIGHT_DAMAGE + combo_level*COMBO_BONUS.
  - combo_level clears on entry to IDLE.
  - Heavy rises during recovery are still ignored.
- Undefined: no chaining; combo_level is tied to 0; light damage is always LIGHT_DAMAGE.

Decomposition:
- Package attack_pkg holds:
  - phase encoding constants
  - anim_state layout
  - default frame and damage constants
  - DMG_W=9, matching the health width
- One sub-module, rise_detect: 1-bit rising-edge detector with synchronous active-low reset that presets prev to 1. Instantiated twice.

Test Plan:
- Reset check: reset_n=0 with btn_light held, then reset_n=1 while still held -> no attack; busy=0 for 10 cycles; a release then press starts STARTUP.
- Light timing: light press, in_range=1 throughout:
  - anim_state 001 for 2 cycles, 010 for 2, 011 for 3, then 000.
  - Exactly one hit_valid pulse with hit_damage=10, one cycle after the first ACTIVE cycle.
- Heavy priority: light and heavy rise in the same cycle -> anim_state=101; hit_damage=25; busy for 13 cycles.
- Range edges: in_range=1 only during STARTUP/RECOVERY -> no hit. in_range=1 only on the last ACTIVE cycle -> one hit pulse, observed while anim_state=011.
- Stun: stunned=1 on the first ACTIVE cycle with in_range=1 -> next cycle IDLE, hit_valid stays 0. A press 1 cycle later starts a new attack.
- Combo (ATTACK_FSM_COMBO_EN): three light presses, each in recovery, in_range=1 -> hit_damage 10, 15, 20. A fourth press during the third recovery is ignored; combo_level returns to 0 at IDLE.
